fp_cvt_share_arbiter: RTL

- Shares one combinational raw-single-to-recoded-double rounding unit among NREQ requesters.
- Arbitrates round-robin and drives the converter's raw-float inputs from a registered issue stage.
- Captures the converter's 65-bit recoded result in a response stage, tagged with requester id and tag.
- Sits between FPU issue ports (e.g. FCVT.D.S, load-promote, divider wrap-up) and the single shared conversion unit instance.

---
 rtl/fp_cvt_share_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fp_cvt_share_arbiter.sv
// Round-robin share of one raw-single -> recoded-double converter among NREQ requesters.
// S1 issue flops drive the converter; S2 captures its result with the requester id and tag.
module fp_cvt_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int TAG_W = 5,
    parameter int ID_W  = $clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_invalidExc,
    input  logic [NREQ-1:0]       req_isNaN,
    input  logic [NREQ-1:0]       req_isInf,
    input  logic [NREQ-1:0]       req_isZero,
    input  logic [NREQ-1:0]       req_sign,
    input  logic [NREQ*10-1:0]    req_sExp,
    input  logic [NREQ*25-1:0]    req_sig,
    input  logic [NREQ*TAG_W-1:0] req_tag,
    output logic                  cvt_invalidExc,
    output logic                  cvt_isNaN,
    output logic                  cvt_isInf,
    output logic                  cvt_isZero,
    output logic                  cvt_sign,
    output logic [9:0]            cvt_sExp,
    output logic [24:0]           cvt_sig,
    input  logic [64:0]           cvt_out,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [64:0]           resp_bits,
    output logic [ID_W-1:0]       resp_id,
    output logic [TAG_W-1:0]      resp_tag,
    output logic                  resp_invalid,
    output logic [15:0]           nan_count,
    output logic                  busy
);

    logic              s1_valid_q, s2_valid_q;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              s1_inv_q, s1_nan_q, s1_inf_q, s1_zero_q, s1_sign_q;
    logic [9:0]        s1_sexp_q;
    logic [24:0]       s1_sig_q;
    logic [ID_W-1:0]   s1_id_q;
    logic [TAG_W-1:0]  s1_tag_q;
    logic [64:0]       s2_bits_q;
    logic [ID_W-1:0]   s2_id_q;
    logic [TAG_W-1:0]  s2_tag_q;
    logic              s2_inv_q;
    logic [15:0]       nan_q;

    logic              s2_free, s1_free, advance, drain, accept;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    int unsigned       arb_idx;

    assign s2_free = ~s2_valid_q | resp_ready;
    assign s1_free = ~s1_valid_q | s2_free;
    assign advance = s1_valid_q & s2_free;
    assign drain   = s2_valid_q & resp_ready;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        arb_idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            arb_idx = (32'(ptr_q) + k) % NREQ;
            if (!grant_vld && req_valid[arb_idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(arb_idx);
            end
        end
    end

    assign accept = grant_vld & s1_free & ~flush & reset;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) ptr_d = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_inv_q   <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_sexp_q  <= '0;
            s1_sig_q   <= '0;
            s1_id_q    <= '0;
            s1_tag_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (flush)        s1_valid_q <= 1'b0;
            else if (s1_free) s1_valid_q <= accept;
            if (accept) begin
                s1_inv_q  <= req_invalidExc[grant_id];
                s1_nan_q  <= req_isNaN[grant_id];
                s1_inf_q  <= req_isInf[grant_id];
                s1_zero_q <= req_isZero[grant_id];
                s1_sign_q <= req_sign[grant_id];
                s1_sexp_q <= req_sExp[32'(grant_id)*10 +: 10];
                s1_sig_q  <= req_sig[32'(grant_id)*25 +: 25];
                s1_id_q   <= grant_id;
                s1_tag_q  <= req_tag[32'(grant_id)*TAG_W +: TAG_W];
            end
        end
    end

    // An idle issue stage presents a clean zero so the converter output stays defined.
    assign cvt_invalidExc = s1_valid_q & s1_inv_q;
    assign cvt_isNaN      = s1_valid_q & s1_nan_q;
    assign cvt_isInf      = s1_valid_q & s1_inf_q;
    assign cvt_isZero     = ~s1_valid_q | s1_zero_q;
    assign cvt_sign       = s1_valid_q & s1_sign_q;
    assign cvt_sExp       = s1_valid_q ? s1_sexp_q : '0;
    assign cvt_sig        = s1_valid_q ? s1_sig_q  : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            s2_bits_q  <= '0;
            s2_id_q    <= '0;
            s2_tag_q   <= '0;
            s2_inv_q   <= 1'b0;
            nan_q      <= '0;
        end else begin
            if (flush)        s2_valid_q <= 1'b0;
            else if (s2_free) s2_valid_q <= s1_valid_q;
            if (advance) begin
                s2_bits_q <= cvt_out;
                s2_id_q   <= s1_id_q;
                s2_tag_q  <= s1_tag_q;
                s2_inv_q  <= s1_inv_q;
            end
            if (drain && s2_inv_q && nan_q != 16'hFFFF) nan_q <= nan_q + 16'd1;
        end
    end

    assign resp_valid   = s2_valid_q;
    assign resp_bits    = s2_bits_q;
    assign resp_id      = s2_id_q;
    assign resp_tag     = s2_tag_q;
    assign resp_invalid = s2_inv_q;
    assign nan_count    = nan_q;
    assign busy         = s1_valid_q | s2_valid_q;

endmodule
